// File: rtl/minority_bist_pkg.sv
// rtl/minority_bist_pkg.sv - shared types, constants and golden model for the minority self-test
package minority_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;

    // Reference response of a 3-input minority gate
    function automatic logic minority_golden(logic [2:0] v);
        return ~((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/minority_bist_if.sv
// rtl/minority_bist_if.sv - sweep control, stimulus and result bundle of the minority self-test
interface minority_bist_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;
    logic       fail_seen;

    modport master (
        input  start, y,
        output a, b, c, busy, done, pass, err_cnt, first_fail, fail_seen
    );

    modport slave (
        output start, y,
        input  a, b, c, busy, done, pass, err_cnt, first_fail, fail_seen
    );
endinterface

// File: rtl/bist_hold_counter.sv
// rtl/bist_hold_counter.sv - per-vector settle counter with clear and terminal flag
module bist_hold_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);
    logic [3:0] r_count;

    // Count settle cycles; a clear always wins so each vector starts from zero
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= 4'd0;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_term = (r_count == 4'(SETTLE - 1));
endmodule

// File: rtl/minority_bist.sv
// rtl/minority_bist.sv - sweeps all eight vectors through an external minority gate and scores it
module minority_bist
    import minority_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    minority_bist_if.master bus
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_fail;
    logic       r_fail_seen;

    logic       w_start_go;
    logic       w_in_drive;
    logic       w_hold_term;
    logic       w_cmp;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // Start is only honoured outside a sweep
    assign w_start_go = bus.start && (r_state != DRIVE);
    assign w_in_drive = (r_state == DRIVE);
    assign w_cmp      = w_in_drive && w_hold_term;
    assign w_mismatch = (bus.y != minority_golden(r_idx));
    assign w_err_next = (w_mismatch && (r_err_cnt != 4'd8)) ? r_err_cnt + 4'd1 : r_err_cnt;

    bist_hold_counter #(
        .SETTLE (SETTLE)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start_go || w_cmp),
        .i_en    (w_in_drive),
        .o_term  (w_hold_term)
    );

    // Sweep sequencer: launch, score each vector at the end of its settle window, report
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= 4'd0;
            r_first_fail <= 3'd0;
            r_fail_seen  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state      <= DRIVE;
                        r_idx        <= 3'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= 4'd0;
                        r_first_fail <= 3'd0;
                        r_fail_seen  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_cmp) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && !r_fail_seen) begin
                            r_first_fail <= r_idx;
                            r_fail_seen  <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a          = r_idx[2];
    assign bus.b          = r_idx[1];
    assign bus.c          = r_idx[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.first_fail = r_first_fail;
    assign bus.fail_seen  = r_fail_seen;
endmodule

// File: tb/tb_minority_bist.sv
// tb/tb_minority_bist.sv - scoreboard bench for minority_bist at SETTLE 1 and 3
module tb_minority_bist;

    localparam int M_GOOD = 0;
    localparam int M_ZERO = 1;
    localparam int M_MAJ  = 2;
    localparam int M_ONE  = 3;

    typedef struct {
        int err;
        int ff;
        int pass;
        int fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic sel;
    int   mode;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    // Behaviour of the gate under test in each fault mode
    function automatic logic resp(int m, logic [2:0] v);
        int ones;
        ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
        case (m)
            M_GOOD:  return (ones <= 1);
            M_ZERO:  return 1'b0;
            M_MAJ:   return (ones >= 2);
            default: return 1'b1;
        endcase
    endfunction

    minority_bist_if bus1();
    minority_bist_if bus3();

    assign bus1.start = start & ~sel;
    assign bus3.start = start & sel;
    assign bus1.y     = resp(mode, {bus1.a, bus1.b, bus1.c});
    assign bus3.y     = resp(mode, {bus3.a, bus3.b, bus3.c});

    minority_bist #(.SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    minority_bist #(.SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    logic       s_done, s_busy, s_pass, s_fs;
    logic [3:0] s_err;
    logic [2:0] s_ff, s_abc;

    always_comb begin
        s_done = bus1.done;
        s_busy = bus1.busy;
        s_pass = bus1.pass;
        s_fs   = bus1.fail_seen;
        s_err  = bus1.err_cnt;
        s_ff   = bus1.first_fail;
        s_abc  = {bus1.a, bus1.b, bus1.c};
        if (sel) begin
            s_done = bus3.done;
            s_busy = bus3.busy;
            s_pass = bus3.pass;
            s_fs   = bus3.fail_seen;
            s_err  = bus3.err_cnt;
            s_ff   = bus3.first_fail;
            s_abc  = {bus3.a, bus3.b, bus3.c};
        end
    end

    task automatic check(string tag, int got, int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int m);
        exp_t e;
        logic want;
        e.err = 0;
        e.ff  = 0;
        e.fs  = 0;
        for (int v = 0; v < 8; v++) begin
            want = ((v & 3) == 3 || (v & 5) == 5 || (v & 6) == 6) ? 1'b0 : 1'b1;
            if (resp(m, 3'(v)) != want) begin
                e.err++;
                if (e.fs == 0) begin
                    e.ff = v;
                    e.fs = 1;
                end
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_abc"},  int'(s_abc),  0);
        check({tag, "_busy"}, int'(s_busy), 0);
        check({tag, "_done"}, int'(s_done), 0);
        check({tag, "_pass"}, int'(s_pass), 0);
        check({tag, "_err"},  int'(s_err),  0);
        check({tag, "_ff"},   int'(s_ff),   0);
        check({tag, "_fs"},   int'(s_fs),   0);
    endtask

    task automatic pop_and_check(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"},  int'(s_err),  e.err);
            check({tag, "_ff"},   int'(s_ff),   e.ff);
            check({tag, "_pass"}, int'(s_pass), e.pass);
            check({tag, "_fs"},   int'(s_fs),   e.fs);
            check({tag, "_busy"}, int'(s_busy), 0);
        end
    endtask

    // Caller has just passed the start edge; count edges until done rises
    task automatic wait_done(string tag, int settle, bit watch_abc);
        int lat;
        int k;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (watch_abc) begin
                k = n / settle;
                if (k > 7) k = 7;
                check({tag, "_abc"}, int'(s_abc), k);
            end
            if (s_done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, lat, 8 * settle);
        pop_and_check(tag);
    endtask

    task automatic sweep(string tag, int m, bit use3);
        sel  = use3;
        mode = m;
        push_exp(m);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy0"}, int'(s_busy), 1);
        check({tag, "_done0"}, int'(s_done), 0);
        wait_done(tag, use3 ? 3 : 1, use3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        mode  = M_GOOD;
        tick();
        tick();
        check_idle("rst1");
        sel = 1'b1;
        check_idle("rst3");
        sel   = 1'b0;
        reset = 1'b0;
        tick();

        sweep("good1", M_GOOD, 1'b0);
        sweep("zero1", M_ZERO, 1'b0);
        sweep("maj1",  M_MAJ,  1'b0);
        sweep("one1",  M_ONE,  1'b0);
        sweep("good3", M_GOOD, 1'b1);
        sweep("zero3", M_ZERO, 1'b1);

        // start held high across a whole sweep: one sweep, then restart after done
        sel  = 1'b0;
        mode = M_ZERO;
        push_exp(M_ZERO);
        start = 1'b1;
        tick();
        wait_done("held1", 1, 1'b0);
        tick();
        check("held_restart_done", int'(s_done), 0);
        check("held_restart_busy", int'(s_busy), 1);
        check("held_restart_err",  int'(s_err),  0);
        check("held_restart_fs",   int'(s_fs),   0);
        mode = M_ONE;
        push_exp(M_ONE);
        start = 1'b0;
        wait_done("held2", 1, 1'b0);

        // reset in the middle of a sweep, at vector 4
        sel   = 1'b0;
        mode  = M_GOOD;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (s_abc == 3'd4) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("rst_mid_reach_idx4", int'(hit), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_mid");
        tick();
        check_idle("rst_mid_hold");
        sweep("post_rst", M_GOOD, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
